// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter and burst sequencer for the single-ported memory
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_BYTES    = 1048576,
    parameter int D_STREAK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    output logic                  i_ack,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_rd_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic                  d_ack,
    output logic                  d_err,
    output logic                  mem_enable,
    output logic                  mem_rd_wr,
    output logic [1:0]            mem_access_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam logic [SW-1:0]       STREAK_LIMIT = SW'(D_STREAK_MAX);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT    = (ADDR_WIDTH + 1)'(MEM_BYTES);

    logic [1:0]            state;
    logic                  owner_d;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_rd_wr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [3:0]            last_beat;
    logic [3:0]            beat;
    logic                  err_q;
    logic [SW-1:0]         streak;

    logic                  grant_i;
    logic                  grant_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [4:0]            sel_beats;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  sel_err;
    logic                  beat_accept;

    function automatic logic [4:0] size_to_beats(input logic [1:0] size);
        case (size)
            2'd0:    return 5'd1;
            2'd1:    return 5'd4;
            2'd2:    return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

    // Grant selection and range check on the request about to be latched
    always_comb begin
        grant_i   = i_req && (!d_req || (streak == STREAK_LIMIT));
        grant_d   = d_req && !grant_i;
        sel_addr  = grant_i ? i_addr : d_addr;
        sel_beats = grant_i ? size_to_beats(i_size) : 5'd1;
        end_addr  = {1'b0, sel_addr} + ((ADDR_WIDTH + 1)'(sel_beats) << 2);
        sel_err   = (sel_addr[1:0] != 2'b00) || (end_addr > MEM_LIMIT);
    end

    assign beat_accept = (state == S_ACCESS) && !mem_busy;

    // Main sequencer: grant/latch in IDLE, step beats in ACCESS, one-cycle RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            lat_addr  <= '0;
            lat_rd_wr <= 1'b0;
            lat_wdata <= '0;
            last_beat <= '0;
            beat      <= '0;
            err_q     <= 1'b0;
            streak    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_i || grant_d) begin
                        owner_d   <= grant_d;
                        lat_addr  <= sel_addr;
                        lat_rd_wr <= grant_i ? 1'b1 : d_rd_wr;
                        lat_wdata <= grant_i ? '0 : d_wdata;
                        last_beat <= 4'(sel_beats - 5'd1);
                        beat      <= '0;
                        err_q     <= sel_err;
                        state     <= sel_err ? S_RESP : S_ACCESS;
                        if (grant_d && i_req) begin
                            streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!mem_busy) begin
                        if (beat == last_beat) begin
                            state <= S_RESP;
                        end else begin
                            beat <= beat + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Register read data of each accepted read beat toward its owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata  <= '0;
            i_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_rvalid <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (beat_accept && lat_rd_wr) begin
                if (owner_d) begin
                    d_rdata  <= mem_data_out;
                    d_rvalid <= 1'b1;
                end else begin
                    i_rdata  <= mem_data_out;
                    i_rvalid <= 1'b1;
                end
            end
        end
    end

    // Completion strobes and memory-side drive decoded from state
    always_comb begin
        i_ack           = (state == S_RESP) && !owner_d;
        d_ack           = (state == S_RESP) && owner_d;
        i_err           = i_ack && err_q;
        d_err           = d_ack && err_q;
        mem_enable      = (state == S_ACCESS);
        mem_rd_wr       = mem_enable && lat_rd_wr;
        mem_access_size = 2'd0;
        mem_addr        = mem_enable ? (lat_addr + (ADDR_WIDTH'(beat) << 2)) : '0;
        mem_data_in     = mem_enable ? lat_wdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int MEM_BYTES = 1048576;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_rd_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_ack;
    logic        d_err;
    logic        mem_enable;
    logic        mem_rd_wr;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [int];
    logic [31:0] ref_mem [int];

    mem_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(MEM_BYTES), .D_STREAK_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_ack(d_ack), .d_err(d_err),
        .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr), .mem_access_size(mem_access_size),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: writes land on the accepting edge, reads are presented mid-cycle
    always @(posedge clk) begin
        if (mem_enable && !mem_busy && !mem_rd_wr) mem[int'(mem_addr >> 2)] = mem_data_in;
    end
    always @(negedge clk) begin
        mem_data_out = mem.exists(int'(mem_addr >> 2)) ? mem[int'(mem_addr >> 2)] : 32'd0;
    end

    function automatic logic [31:0] ref_rd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
    endfunction

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [233:0] all_outputs();
        return {i_rdata, i_rvalid, i_ack, i_err, d_rdata, d_rvalid, d_ack, d_err,
                mem_enable, mem_rd_wr, mem_access_size, mem_addr, mem_data_in};
    endfunction

    // One request from one requester, checked against the abstract model
    task automatic run_txn(input string name, input bit is_d, input bit rd_wr,
                           input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input logic [63:0] busy_pat,
                           output int lat, output bit got_err, output logic [31:0] first_data);
        int          beats;
        bit          rd;
        bit          exp_err;
        int          exp_lat;
        int          n;
        int          c;
        int          en_cycles;
        bit          other;
        bit          bad_drive;
        bit          data_ok;
        bit          addr_ok;
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        logic [31:0] addr_q[$];
        beats = is_d ? 1 : (size == 2'd0 ? 1 : size == 2'd1 ? 4 : size == 2'd2 ? 8 : 16);
        rd = is_d ? rd_wr : 1'b1;
        exp_err = (addr[1:0] != 2'b00) || (longint'(addr) + 4 * beats > MEM_BYTES);
        if (exp_err) begin
            exp_lat = 1;
        end else begin
            n = 0;
            c = 0;
            while (n < beats) begin
                c++;
                if (!busy_pat[c[5:0]]) n++;
            end
            exp_lat = c + 1;
            if (rd) for (int b = 0; b < beats; b++) exp_q.push_back(ref_rd(int'(addr >> 2) + b));
        end
        lat = -1;
        got_err = 1'b0;
        first_data = 32'd0;
        en_cycles = 0;
        other = 1'b0;
        bad_drive = 1'b0;
        @(negedge clk);
        mem_busy = 1'b0;
        if (is_d) begin
            d_req = 1'b1; d_rd_wr = rd_wr; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr; i_size = size;
        end
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            mem_busy = (k < 64) ? busy_pat[k[5:0]] : 1'b0;
            if (mem_enable) begin
                en_cycles++;
                if (mem_rd_wr != rd || mem_access_size != 2'd0) bad_drive = 1'b1;
                if (!rd && mem_data_in != wdata) bad_drive = 1'b1;
                if (!mem_busy) addr_q.push_back(mem_addr);
            end
            if (is_d) begin
                if (d_rvalid) got_q.push_back(d_rdata);
                if (i_rvalid || i_ack || i_err) other = 1'b1;
                if (d_ack) begin lat = k; got_err = d_err; break; end
            end else begin
                if (i_rvalid) got_q.push_back(i_rdata);
                if (d_rvalid || d_ack || d_err) other = 1'b1;
                if (i_ack) begin lat = k; got_err = i_err; break; end
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        mem_busy = 1'b0;
        if (got_q.size() > 0) first_data = got_q[0];
        check({name, "/latency"}, lat == exp_lat, lat, exp_lat);
        check({name, "/err"}, got_err == exp_err, got_err, exp_err);
        check({name, "/rvalid_count"}, got_q.size() == exp_q.size(), got_q.size(), exp_q.size());
        data_ok = (got_q.size() == exp_q.size());
        for (int b = 0; b < got_q.size() && data_ok; b++)
            if (got_q[b] !== exp_q[b]) begin
                data_ok = 1'b0;
                check({name, "/rdata"}, 1'b0, got_q[b], exp_q[b]);
            end
        if (data_ok && exp_q.size() > 0) check({name, "/rdata"}, 1'b1, 0, 0);
        if (exp_err) begin
            check({name, "/no_mem_cycle"}, en_cycles == 0, en_cycles, 0);
        end else begin
            addr_ok = (addr_q.size() == beats);
            for (int b = 0; b < addr_q.size() && addr_ok; b++)
                if (addr_q[b] != addr + 32'(4 * b)) addr_ok = 1'b0;
            check({name, "/mem_addr_seq"}, addr_ok, addr_q.size(), beats);
        end
        check({name, "/mem_drive"}, !bad_drive, bad_drive, 0);
        check({name, "/non_owner_quiet"}, !other, other, 0);
        if (!rd && !exp_err) ref_mem[int'(addr >> 2)] = wdata;
    endtask

    typedef struct {
        bit          is_d;
        bit          rd_wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [63:0] busy;
        bit          exp_err;
        int          exp_lat;
        bit          has_d0;
        logic [31:0] exp_d0;
    } vec_t;

    vec_t        vecs[11];
    int          lat;
    bit          got_err;
    logic [31:0] first_data;
    string       seq;
    bit          both;
    int          nacc;

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0; i_size = '0;
        d_req = 1'b0; d_rd_wr = 1'b0; d_addr = '0; d_wdata = '0;
        mem_busy = 1'b0; mem_data_out = '0;

        vecs[0]  = '{1, 0, 32'd0,       2'd0, 32'd234,        64'h0,  0, 2, 0, 32'd0};
        vecs[1]  = '{1, 1, 32'd0,       2'd0, 32'd0,          64'h0,  0, 2, 1, 32'd234};
        vecs[2]  = '{1, 0, 32'd4,       2'd0, 32'd1537628013, 64'h0,  0, 2, 0, 32'd0};
        vecs[3]  = '{1, 0, 32'd8,       2'd0, 32'd537628013,  64'h0,  0, 2, 0, 32'd0};
        vecs[4]  = '{1, 0, 32'd12,      2'd0, 32'd2537628013, 64'h0,  0, 2, 0, 32'd0};
        vecs[5]  = '{0, 1, 32'd0,       2'd1, 32'd0,          64'h0,  0, 5, 1, 32'd234};
        vecs[6]  = '{0, 1, 32'd1048572, 2'd0, 32'd0,          64'h0,  0, 2, 1, 32'd0};
        vecs[7]  = '{0, 1, 32'd1048572, 2'd1, 32'd0,          64'h0,  1, 1, 0, 32'd0};
        vecs[8]  = '{1, 0, 32'd1048576, 2'd0, 32'd77,         64'h0,  1, 1, 0, 32'd0};
        vecs[9]  = '{1, 1, 32'd2,       2'd0, 32'd0,          64'h0,  1, 1, 0, 32'd0};
        vecs[10] = '{0, 1, 32'd0,       2'd1, 32'd0,          64'h1C, 0, 8, 1, 32'd234};

        repeat (3) @(negedge clk);
        check("reset_outputs_zero", all_outputs() == '0, all_outputs(), 0);
        reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].is_d, vecs[v].rd_wr, vecs[v].addr,
                    vecs[v].size, vecs[v].wdata, vecs[v].busy, lat, got_err, first_data);
            check($sformatf("vec%0d/tbl_latency", v), lat == vecs[v].exp_lat, lat, vecs[v].exp_lat);
            check($sformatf("vec%0d/tbl_err", v), got_err == vecs[v].exp_err, got_err, vecs[v].exp_err);
            if (vecs[v].has_d0)
                check($sformatf("vec%0d/tbl_first_data", v), first_data == vecs[v].exp_d0,
                      first_data, vecs[v].exp_d0);
        end

        // Reset asserted mid-burst while the third beat is on the bus
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'd0; i_size = 2'd1;
        nacc = 0;
        for (int k = 1; k <= 10 && nacc < 2; k++) begin
            @(negedge clk);
            if (mem_enable) nacc++;
        end
        @(negedge clk);
        check("midburst_addr_beat2", mem_addr == 32'd8, mem_addr, 8);
        #2 reset = 1'b1;
        #1 check("midburst_reset_zero", all_outputs() == '0, all_outputs(), 0);
        i_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_txn("post_reset_read", 1'b1, 1'b1, 32'd0, 2'd0, 32'd0, 64'h0, lat, got_err, first_data);
        check("post_reset_data", first_data == 32'd234, first_data, 234);

        // Both requesters held high: data streak capped at four
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'd0; i_size = 2'd0;
        d_req = 1'b1; d_rd_wr = 1'b1; d_addr = 32'd4;
        seq = "";
        both = 1'b0;
        for (int k = 0; k < 200 && seq.len() < 10; k++) begin
            @(negedge clk);
            if (d_ack && i_ack) both = 1'b1;
            if (d_ack) seq = {seq, "d"};
            else if (i_ack) seq = {seq, "i"};
        end
        i_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (seq != "ddddiddddi") begin
            errors++;
            $display("FAIL grant_order: got %s, expected ddddiddddi", seq);
        end
        check("grant_exclusive_ack", !both, both, 0);
        repeat (2) @(negedge clk);

        // Random traffic against the abstract model, including random stalls
        for (int t = 0; t < 40; t++) begin
            bit          is_d;
            bit          rw;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [63:0] bp;
            int          r;
            is_d = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 7) a = 32'($urandom_range(0, 31) * 4);
            else if (r == 7) a = 32'(MEM_BYTES - 4 * $urandom_range(1, 20));
            else if (r == 8) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else a = 32'(MEM_BYTES + 4 * $urandom_range(0, 3));
            bp = '0;
            for (int c = 1; c <= 20; c++) if ($urandom_range(0, 3) == 0) bp[c] = 1'b1;
            run_txn($sformatf("rand%0d", t), is_d, rw, a, sz, $urandom, bp, lat, got_err, first_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported `memory` block of the MIPS processor.
- Shares that memory between the instruction-fetch requester (i_*, read-only, word or burst) and the data requester (d_*, single-word read/write).
- Splits bursts into single-word memory accesses.
- Range-checks every request and returns per-beat read data plus a completion strobe to the winning requester.

Parameters:
- DATA_WIDTH, 32, width of data buses
- ADDR_WIDTH, 32, width of byte addresses
- MEM_BYTES, 1048576, size of backing memory in bytes; valid addresses are 0..MEM_BYTES-1
- D_STREAK_MAX, 4, max consecutive data grants while i_req is pending

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction-fetch request, held until i_ack
- i_addr  in  ADDR_WIDTH  fetch start byte address
- i_size  in  2  beats: 0=1, 1=4, 2=8, 3=16 words
- i_rdata  out  DATA_WIDTH  fetch read data
- i_rvalid  out  1  i_rdata valid, one pulse per beat
- i_ack  out  1  one-cycle completion pulse
- i_err  out  1  valid with i_ack; request rejected
- d_req  in  1  data request, held until d_ack
- d_rd_wr  in  1  1=read, 0=write
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  write data
- d_rdata  out  DATA_WIDTH  data read data
- d_rvalid  out  1  d_rdata valid
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  valid with d_ack; request rejected
- mem_enable  out  1  to memory enable
- mem_rd_wr  out  1  to memory rd_wr (1=read)
- mem_access_size  out  2  to memory access_size; constant 2'd0 (single word)
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_data_in  out  DATA_WIDTH  to memory data_in
- mem_data_out  in  DATA_WIDTH  from memory data_out
- mem_busy  in  1  from memory busy; stalls current beat

Behaviour:
- Reset (async, any time, including mid-burst):
  - State goes to IDLE; beat counter and streak counter clear.
  - All outputs read 0 (mem_access_size 0); any in-flight access is abandoned.
- States: IDLE, ACCESS, RESP.
- IDLE, sampling requests at each rising edge:
  - Priority is d over i.
  - Exception: if i_req=1 and streak==D_STREAK_MAX, i wins.
  - Streak increments on each d grant made while i_req=1; it clears on any i grant or when i_req=0 at grant time.
  - Winner's addr/size/rd_wr/wdata are latched.
  - Error check on latched values: addr[1:0]!=0, or addr+4*beats > MEM_BYTES → RESP with err=1, no memory cycle.
  - Otherwise → ACCESS, beat=0.
- ACCESS:
  - Drives mem_enable=1, mem_addr=base+4*beat, mem_rd_wr=latched rd_wr, mem_data_in=latched wdata. Instruction requests always read.
  - At each rising edge with mem_busy=0: beat is accepted. For reads, mem_data_out is registered to the owner's rdata and rvalid pulses the next cycle.
  - mem_busy=1 holds the beat: no advance, no rvalid.
  - After the last beat is accepted → RESP.
- RESP:
  - One cycle: owner's ack=1, err per check, mem_enable=0.
  - On a successful read, the last beat's rvalid coincides with ack; writes produce no rvalid.
  - Next state is IDLE. Requests are not sampled in RESP; the requester drops req on the edge where it sees ack.
- Latency:
  - Single word, no stall: req sampled at edge N, ack high in cycle after edge N+1 (2 cycles).
  - Burst of k beats: k+1 cycles.
  - Error: 1 cycle.
- rdata holds its last value between rvalids. The non-owner's rvalid/ack/err stay 0.
- Simultaneous i_req and d_req with streak<D_STREAK_MAX: d wins, i waits with its inputs held stable.
- Requester inputs changing while not in IDLE are ignored; the latched copy is used.

Test Plan:
- Reset during 4-beat fetch at beat 2 → all outputs 0 immediately. After release, new d read of addr 0 completes normally with data 234 (previously written).
- d write 234 @0, then d read @0 → d_ack after 2 cycles, d_rvalid with d_rdata=234, d_err=0, no i_* activity.
- Preload words 234, 1537628013, 537628013, 2537628013 @0..12; i_req size=1 @0 → four consecutive i_rvalid with those values, mem_addr 0,4,8,12, i_ack with the 4th.
- i_req size=0 @1048572 → data returned, i_err=0. size=1 @1048572 → i_ack, i_err=1 in 1 cycle, mem_enable never high. d write @1048576 → d_err=1. d read @2 → d_err=1.
- i_req and d_req held high continuously → grants d,d,d,d,i,d,d,d,d,i. Force mem_busy=1 for 3 cycles mid-burst → beat held, mem_addr stable, no extra rvalid, total latency +3.
